// File: rtl/rv32_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: class codes,
// base opcodes and rejection reasons.
package rv32_enc_pkg;

  typedef enum logic [3:0] {
    LOAD   = 4'd0,
    STORE  = 4'd1,
    RTYPE  = 4'd2,
    ITYPE  = 4'd3,
    BRANCH = 4'd4,
    JAL    = 4'd5,
    JALR   = 4'd6,
    LUI    = 4'd7,
    AUIPC  = 4'd8
  } instr_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_CLASS  = 3'd1;
  localparam logic [2:0] ERR_IMM_IS = 3'd2;
  localparam logic [2:0] ERR_IMM_B  = 3'd3;
  localparam logic [2:0] ERR_IMM_J  = 3'd4;
  localparam logic [2:0] ERR_IMM_U  = 3'd5;
  localparam logic [2:0] ERR_SHAMT  = 3'd6;
  localparam logic [2:0] ERR_ALT    = 3'd7;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: assembles the RV32I word for one request and
// reports the first validation failure, if any.
module instr_pack
  import rv32_enc_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err,
  output logic [2:0]  err_code
);

  logic signed [31:0] simm;
  logic fits_is, fits_b, fits_j, is_shift;

  assign simm     = imm;
  assign fits_is  = (simm >= -32'sd2048) && (simm <= 32'sd2047);
  assign fits_b   = (simm >= -32'sd4096) && (simm <= 32'sd4094);
  assign fits_j   = (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    instr    = '0;
    err_code = ERR_NONE;
    case (cls)
      LOAD: begin
        if (!fits_is) err_code = ERR_IMM_IS;
        instr = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      end
      STORE: begin
        if (!fits_is) err_code = ERR_IMM_IS;
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      end
      RTYPE: begin
        if (alt && (funct3 != 3'b000) && (funct3 != 3'b101)) err_code = ERR_ALT;
        instr = {1'b0, alt, 5'b00000, rs2, rs1, funct3, rd, OP_RTYPE};
      end
      ITYPE: begin
        // Range is checked before shift amount so the lower code wins.
        if (!fits_is) err_code = ERR_IMM_IS;
        else if (is_shift && ((simm < 32'sd0) || (simm > 32'sd31))) err_code = ERR_SHAMT;
        if (is_shift) instr = {1'b0, alt, 5'b00000, imm[4:0], rs1, funct3, rd, OP_ITYPE};
        else          instr = {imm[11:0], rs1, funct3, rd, OP_ITYPE};
      end
      BRANCH: begin
        if (!fits_b || imm[0]) err_code = ERR_IMM_B;
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      end
      JAL: begin
        if (!fits_j || imm[0]) err_code = ERR_IMM_J;
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      end
      JALR: begin
        if (!fits_is) err_code = ERR_IMM_IS;
        instr = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      end
      LUI: begin
        if (imm[11:0] != 12'd0) err_code = ERR_IMM_U;
        instr = {imm[31:12], rd, OP_LUI};
      end
      AUIPC: begin
        if (imm[11:0] != 12'd0) err_code = ERR_IMM_U;
        instr = {imm[31:12], rd, OP_AUIPC};
      end
      default: err_code = ERR_CLASS;
    endcase
  end

  assign err = (err_code != ERR_NONE);

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: one output register with valid/ready, an
// auto-incrementing byte address and a saturating emitted-word counter.
module instr_encoder
  import rv32_enc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [2:0]        err_code,
  output logic [15:0]       word_count
);

  logic [31:0]       pack_instr;
  logic              pack_err;
  logic [2:0]        pack_code;
  logic [ADDR_W-1:0] counter;
  logic [ADDR_W-1:0] next_addr;
  logic              accept;
  logic              hs;

  instr_pack u_pack (
    .cls      (in_class),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .funct3   (in_funct3),
    .alt      (in_alt),
    .imm      (in_imm),
    .instr    (pack_instr),
    .err      (pack_err),
    .err_code (pack_code)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid && out_ready;

  // Address the next accepted word would get; also the counter's next value.
  always_comb begin
    next_addr = counter;
    if (hs)
      next_addr = counter + ADDR_W'(4);
    else if (addr_load && !out_valid)
      next_addr = {addr_base[ADDR_W-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      counter    <= BASE_ADDR;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_addr   <= BASE_ADDR;
      err_valid  <= 1'b0;
      err_code   <= '0;
      word_count <= '0;
    end else begin
      counter <= next_addr;
      if (accept && !pack_err) begin
        out_valid <= 1'b1;
        out_instr <= pack_instr;
        out_addr  <= next_addr;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
      err_valid <= accept && pack_err;
      err_code  <= (accept && pack_err) ? pack_code : 3'd0;
      if (hs && (word_count != 16'hFFFF))
        word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded vectors, error codes,
// back-pressure, address wrap, count saturation and mid-stream reset.
module tb_instr_encoder;
  import rv32_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_class = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [31:0] in_imm = '0;
  logic        addr_load = 1'b0;
  logic [31:0] addr_base = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [15:0] word_count;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t good[13];
  vec_t bad[11];

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_class   (in_class),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_alt     (in_alt),
    .in_imm     (in_imm),
    .addr_load  (addr_load),
    .addr_base  (addr_base),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_class  = v.cls;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_alt    = v.alt;
    in_imm    = v.imm;
  endtask

  // Present one request for a single edge, then drop in_valid.
  task automatic send(input vec_t v);
    drive(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  vec_t addi5;
  vec_t lui5;

  initial begin
    good[0]  = '{ITYPE,  5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5,          32'h00500093};
    good[1]  = '{STORE,  5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8,          32'h0020A423};
    good[2]  = '{BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd4,        32'hFE208EE3};
    good[3]  = '{JAL,    5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8,          32'h008000EF};
    good[4]  = '{LUI,    5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000,   32'h123452B7};
    good[5]  = '{ITYPE,  5'd3, 5'd3, 5'd0, 3'd5, 1'b1, 32'd7,          32'h4071D193};
    good[6]  = '{RTYPE,  5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 32'd0,          32'h403100B3};
    good[7]  = '{LOAD,   5'd5, 5'd1, 5'd0, 3'd2, 1'b0, -32'sd4,        32'hFFC0A283};
    good[8]  = '{JALR,   5'd1, 5'd5, 5'd0, 3'd3, 1'b0, 32'd0,          32'h000280E7};
    good[9]  = '{AUIPC,  5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00001000,   32'h00001117};
    good[10] = '{BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4094,       32'h7E000FE3};
    good[11] = '{ITYPE,  5'd0, 5'd0, 5'd0, 3'd0, 1'b0, -32'sd2048,     32'h80000013};
    good[12] = '{JAL,    5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFF00000,   32'h8000006F};

    // exp holds the required err_code.
    bad[0]  = '{ITYPE,  5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048,       32'd2};
    bad[1]  = '{BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3,          32'd3};
    bad[2]  = '{4'd15,  5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0,          32'd1};
    bad[3]  = '{STORE,  5'd0, 5'd1, 5'd2, 3'd2, 1'b0, -32'sd2049,     32'd2};
    bad[4]  = '{BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd4096,       32'd3};
    bad[5]  = '{JAL,    5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1,          32'd4};
    bad[6]  = '{JAL,    5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00100000,   32'd4};
    bad[7]  = '{LUI,    5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345001,   32'd5};
    bad[8]  = '{ITYPE,  5'd1, 5'd1, 5'd0, 3'd1, 1'b0, 32'd32,         32'd6};
    bad[9]  = '{RTYPE,  5'd1, 5'd1, 5'd2, 3'd1, 1'b1, 32'd0,          32'd7};
    bad[10] = '{ITYPE,  5'd1, 5'd1, 5'd0, 3'd5, 1'b0, -32'sd1,        32'd6};

    addi5 = good[0];
    lui5  = good[4];

    // Reset with a request present: it must be ignored.
    drive(addi5);
    in_valid = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    check("post_rst_idle", 32'(out_valid), 32'd0);

    // Back-to-back valid words, one per cycle.
    for (int i = 0; i < 13; i++) begin
      send(good[i]);
      check($sformatf("good%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("good%0d_instr", i), out_instr, good[i].exp);
      check($sformatf("good%0d_addr", i), out_addr, 32'(i * 4));
    end
    tick();
    check("good_drain_valid", 32'(out_valid), 32'd0);
    check("good_count", 32'(word_count), 32'd13);

    // Rejected requests.
    for (int i = 0; i < 11; i++) begin
      send(bad[i]);
      check($sformatf("bad%0d_err_valid", i), 32'(err_valid), 32'd1);
      check($sformatf("bad%0d_err_code", i), 32'(err_code), bad[i].exp);
      check($sformatf("bad%0d_out_valid", i), 32'(out_valid), 32'd0);
    end
    tick();
    check("err_pulse_end", 32'(err_valid), 32'd0);
    check("err_count_kept", 32'(word_count), 32'd13);
    send(addi5);
    check("after_err_addr", out_addr, 32'h34);
    check("after_err_instr", out_instr, 32'h00500093);
    tick();
    check("after_err_count", 32'(word_count), 32'd14);

    // Back-pressure; addr_load while a word is pending must be ignored.
    out_ready = 1'b0;
    send(addi5);
    drive(lui5);
    in_valid  = 1'b1;
    addr_load = 1'b1;
    addr_base = 32'h100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_instr", i), out_instr, 32'h00500093);
      check($sformatf("bp%0d_addr", i), out_addr, 32'h38);
    end
    addr_load = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_release_instr", out_instr, 32'h123452B7);
    check("bp_release_addr", out_addr, 32'h3C);
    check("bp_release_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_drain_valid", 32'(out_valid), 32'd0);
    check("bp_count", 32'(word_count), 32'd16);

    // Address reload with low bits masked, then wrap.
    addr_load = 1'b1;
    addr_base = 32'hFFFF_FFFF;
    send(addi5);
    addr_load = 1'b0;
    check("wrap_addr0", out_addr, 32'hFFFF_FFFC);
    send(lui5);
    check("wrap_addr1", out_addr, 32'h0000_0000);
    check("wrap_instr1", out_instr, 32'h123452B7);
    tick();
    check("wrap_count", 32'(word_count), 32'd18);

    // Saturation of the emitted-word counter.
    drive(addi5);
    in_valid = 1'b1;
    repeat (65530) tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("sat_count", 32'(word_count), 32'hFFFF);

    // Reset with a word pending.
    out_ready = 1'b0;
    send(addi5);
    check("mid_pending", 32'(out_valid), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(word_count), 32'd0);
    check("mid_rst_addr", out_addr, 32'd0);
    tick();
    check("mid_rst_count2", 32'(word_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
